seq_magnitude_comparator: RTL and testbench
===========================================

// Module: seq_magnitude_comparator
// PURPOSE
//   Parametrised, multi-cycle magnitude comparator; successor to the fixed 4-bit combinational comparator.
//   Compares two WIDTH-bit operands DIGIT bits per cycle, MSB digit first, in signed or unsigned mode.
//   Optionally stops at the first differing digit. Start/done handshake; results held between operations.
//   Intended for datapaths where wide comparisons must not sit on the critical path.
// PARAMETERS
//   WIDTH      16  operand width in bits; WIDTH % DIGIT == 0 required
//   DIGIT      4   bits compared per cycle; NDIG = WIDTH/DIGIT digits
//   EARLY_EXIT 1   1: finish at first differing digit; 0: always scan all NDIG digits
// PORTS
//   clk          in   1               rising-edge clock
//   rst_n        in   1               synchronous reset, active-low
//   start        in   1               request; sampled only in IDLE
//   signed_mode  in   1               1: two's-complement compare; 0: unsigned; sampled with start
//   a            in   WIDTH           operand A, sampled with start
//   b            in   WIDTH           operand B, sampled with start
//   busy         out  1               high while in COMPARE
//   done         out  1               one-cycle pulse; results valid
//   a_gt_b       out  1               A > B
//   a_eq_b       out  1               A == B
//   a_lt_b       out  1               A < B
//   cycles       out  $clog2(NDIG)+1  digits examined in last operation (1..NDIG)
// BEHAVIOUR
//   Reset: rst_n==0 at a rising edge gives state=IDLE and busy=done=a_gt_b=a_eq_b=a_lt_b=0, cycles=0.
//     Reset overrides all other inputs.
//   FSM states: IDLE, COMPARE, DONE.
//   IDLE: if start==1, on the next edge:
//     - register a and b; when signed_mode==1, invert the MSB of both so the compare is unsigned;
//     - set idx=NDIG-1 and cnt=0; clear the internal decided flag;
//     - go to COMPARE.
//   COMPARE, each edge:
//     - examine digit idx; cnt += 1;
//     - if not yet decided and the digits differ, record gt/lt from that digit and set decided.
//   COMPARE exit:
//     - EARLY_EXIT=1: a difference found, or idx==0, moves to DONE.
//     - EARLY_EXIT=0: only idx==0 moves to DONE; the first differing digit still sets the result.
//     - Otherwise idx -= 1.
//   Result load: on the edge entering DONE, load a_gt_b/a_eq_b/a_lt_b (exactly one high) and cycles=cnt.
//     a_eq_b=1 only when all NDIG digits are equal.
//   DONE: done=1 for exactly one cycle, then go to IDLE. busy=0.
//   Latency: start sampled at edge E0; done is high in the cycle after edge Ek, where k = cycles.
//     k=NDIG when EARLY_EXIT=0 or the operands are equal. Next start is accepted from IDLE (after DONE).
//   start while busy or in DONE: ignored, not queued. Inputs a, b, signed_mode are don't-care outside IDLE.
//   Result outputs and cycles hold their values until the next operation's DONE entry or reset.
//   Reset mid-COMPARE: the operation is aborted, no done pulse is produced, outputs are cleared.
// TESTING (WIDTH=16, DIGIT=4 unless noted)
//   1. a=16'h1234, b=16'h1234, unsigned -> done 4 cycles after start; a_eq_b=1, cycles=4.
//   2. a=16'h8000, b=16'h7FFF: unsigned -> a_gt_b=1, cycles=1; signed -> a_lt_b=1, cycles=1.
//   3. a=16'h12A0, b=16'h12B0 -> a_lt_b=1, cycles=3. With EARLY_EXIT=0 -> a_lt_b=1, cycles=4.
//   4. Signed boundary cases:
//      - a=16'hFFFF, b=16'h0001 -> a_lt_b=1, cycles=1;
//      - a=16'hFFFE, b=16'hFFFF -> a_lt_b=1, cycles=4.
//   5. start pulsed during COMPARE with new operands -> ignored; first result unchanged; single done pulse.
//   6. rst_n=0 for 1 cycle mid-COMPARE -> no done, all outputs 0.
//      Next start with a=16'h0005, b=16'h0003 -> a_gt_b=1, cycles=4.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands DIGIT bits per clock, MSB digit first,
// in signed or unsigned mode, with a start/done handshake and results held between operations.
module seq_magnitude_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          signed_mode,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic                          busy,
    output logic                          done,
    output logic                          a_gt_b,
    output logic                          a_eq_b,
    output logic                          a_lt_b,
    output logic [$clog2(WIDTH/DIGIT):0]  cycles
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW   = $clog2(NDIG) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [IDXW-1:0]   r_idx;
    logic [CW-1:0]     r_cnt;
    logic              r_decided;
    logic              r_gt;
    logic              r_lt;

    logic [WIDTH-1:0]  w_msb_mask;
    logic [DIGIT-1:0]  w_dig_a;
    logic [DIGIT-1:0]  w_dig_b;
    logic              w_diff;
    logic              w_dec_now;
    logic              w_gt_now;
    logic              w_lt_now;
    logic              w_last;
    logic              w_exit;
    logic [CW-1:0]     w_cnt_next;

    // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
    assign w_msb_mask = {signed_mode, {(WIDTH-1){1'b0}}};

    assign w_dig_a    = r_a[r_idx*DIGIT +: DIGIT];
    assign w_dig_b    = r_b[r_idx*DIGIT +: DIGIT];
    assign w_diff     = (w_dig_a != w_dig_b);

    // Only the most significant differing digit decides; later digits cannot override it.
    assign w_dec_now  = r_decided | w_diff;
    assign w_gt_now   = r_decided ? r_gt : (w_diff && (w_dig_a > w_dig_b));
    assign w_lt_now   = r_decided ? r_lt : (w_diff && (w_dig_a < w_dig_b));

    assign w_last     = (r_idx == '0);
    assign w_exit     = w_last || ((EARLY_EXIT != 0) && w_dec_now);
    assign w_cnt_next = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_gt_b    <= 1'b0;
            a_eq_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            cycles    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a       <= a ^ w_msb_mask;
                        r_b       <= b ^ w_msb_mask;
                        r_idx     <= IDXW'(NDIG - 1);
                        r_cnt     <= '0;
                        r_decided <= 1'b0;
                        r_gt      <= 1'b0;
                        r_lt      <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_COMPARE;
                    end
                end

                S_COMPARE: begin
                    r_cnt     <= w_cnt_next;
                    r_decided <= w_dec_now;
                    r_gt      <= w_gt_now;
                    r_lt      <= w_lt_now;
                    if (w_exit) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        a_gt_b  <= w_gt_now;
                        a_lt_b  <= w_lt_now;
                        a_eq_b  <= ~w_dec_now;
                        cycles  <= w_cnt_next;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench: two comparators (early exit on/off) share stimulus; a monitor pops
// model-generated expectations whenever a done pulse appears.
module tb_seq_magnitude_comparator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [15:0] a;
    logic [15:0] b;

    logic        busy_ee, done_ee, gt_ee, eq_ee, lt_ee;
    logic [2:0]  cyc_ee;
    logic        busy_ne, done_ne, gt_ne, eq_ne, lt_ne;
    logic [2:0]  cyc_ne;

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_ee), .done(done_ee), .a_gt_b(gt_ee),
        .a_eq_b(eq_ee), .a_lt_b(lt_ee), .cycles(cyc_ee)
    );

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) dut_ne (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_ne), .done(done_ne), .a_gt_b(gt_ne),
        .a_eq_b(eq_ne), .a_lt_b(lt_ne), .cycles(cyc_ne)
    );

    typedef struct {
        logic   gt;
        logic   eq;
        logic   lt;
        int     k;
        longint t0;
    } exp_t;

    exp_t   q_ee[$];
    exp_t   q_ne[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc_cnt = 0;
    logic   prev_ee = 1'b0;
    logic   prev_ne = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic; digit count from the top differing bit.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic s, input bit early, input longint t0);
        exp_t        e;
        logic [15:0] d;
        int          k;
        bit          found;
        d = x ^ y;
        k = 4;
        found = 0;
        if (s) begin
            e.gt = ($signed(x) > $signed(y));
            e.lt = ($signed(x) < $signed(y));
        end else begin
            e.gt = (x > y);
            e.lt = (x < y);
        end
        e.eq = (x == y);
        if (early && d != 0) begin
            for (int i = 15; i >= 0; i--) begin
                if (!found && d[i]) begin
                    found = 1;
                    k = 4 - i / 4;
                end
            end
        end
        e.k  = k;
        e.t0 = t0;
        return e;
    endfunction

    task automatic monitor_one(input int id, input logic d, input logic gt, input logic eq,
                               input logic lt, input logic bsy, input logic [2:0] cy,
                               input logic prev_d);
        exp_t  e;
        string p;
        p = (id == 0) ? "ee" : "ne";
        if (d) begin
            check({p, "_done_one_cycle"}, prev_d, 0);
            if ((id == 0 && q_ee.size() == 0) || (id == 1 && q_ne.size() == 0)) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s_unexpected_done: got done=1, expected no done", p);
            end else begin
                e = (id == 0) ? q_ee.pop_front() : q_ne.pop_front();
                check({p, "_a_gt_b"}, gt, e.gt);
                check({p, "_a_eq_b"}, eq, e.eq);
                check({p, "_a_lt_b"}, lt, e.lt);
                check({p, "_cycles"}, cy, e.k);
                check({p, "_latency"}, cyc_cnt - e.t0, e.k);
                check({p, "_busy_at_done"}, bsy, 0);
            end
        end
    endtask

    always @(negedge clk) begin
        monitor_one(0, done_ee, gt_ee, eq_ee, lt_ee, busy_ee, cyc_ee, prev_ee);
        monitor_one(1, done_ne, gt_ne, eq_ne, lt_ne, busy_ne, cyc_ne, prev_ne);
        prev_ee = done_ee;
        prev_ne = done_ne;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q_ee.size() != 0 || q_ne.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q_ee.size() != 0 || q_ne.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got %0d/%0d results pending, expected 0/0",
                     q_ee.size(), q_ne.size());
            q_ee.delete();
            q_ne.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic s);
        @(negedge clk);
        a = ta;
        b = tb_v;
        signed_mode = s;
        start = 1'b1;
        q_ee.push_back(model(ta, tb_v, s, 1, cyc_cnt + 1));
        q_ne.push_back(model(ta, tb_v, s, 0, cyc_cnt + 1));
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic s);
        issue(ta, tb_v, s);
        wait_idle();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ee_busy"},   busy_ee, 0);
        check({tag, "_ee_done"},   done_ee, 0);
        check({tag, "_ee_gt"},     gt_ee, 0);
        check({tag, "_ee_eq"},     eq_ee, 0);
        check({tag, "_ee_lt"},     lt_ee, 0);
        check({tag, "_ee_cycles"}, cyc_ee, 0);
        check({tag, "_ne_busy"},   busy_ne, 0);
        check({tag, "_ne_gt"},     gt_ne, 0);
        check({tag, "_ne_eq"},     eq_ne, 0);
        check({tag, "_ne_cycles"}, cyc_ne, 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          mode;

        rst_n = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        a = 16'h0;
        b = 16'h0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        do_op(16'h1234, 16'h1234, 1'b0);
        do_op(16'h8000, 16'h7FFF, 1'b0);
        do_op(16'h8000, 16'h7FFF, 1'b1);
        do_op(16'h12A0, 16'h12B0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b1);
        do_op(16'hFFFE, 16'hFFFF, 1'b1);

        // start pulsed mid-operation with new operands must be dropped
        issue(16'h1234, 16'h1234, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a = 16'h0001;
        b = 16'hF000;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (6) @(negedge clk);

        // reset mid-compare aborts the operation without a done pulse
        issue(16'h4321, 16'h4321, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        q_ee.delete();
        q_ne.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check_cleared("midrst");
        repeat (6) @(negedge clk);
        do_op(16'h0005, 16'h0003, 1'b0);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0)      rb = ra;
            else if (mode == 1) rb = ra ^ (16'h0001 << $urandom_range(0, 15));
            else                rb = 16'($urandom);
            do_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        check("queue_ee_empty", q_ee.size(), 0);
        check("queue_ne_empty", q_ne.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
